// File: rtl/syscall_console_responder.sv
// Syscall responder: prints signed ints / single chars as an ASCII byte stream and services exit.
// Define SYSCALL_STATS_EN to build the serviced-call and transferred-byte counters.
module syscall_console_responder #(
  parameter logic [31:0] CODE_PRINT_INT    = 32'd1,
  parameter logic [31:0] CODE_EXIT         = 32'd10,
  parameter logic [31:0] CODE_PRINT_CHAR   = 32'd11,
  parameter bit          NEWLINE_AFTER_INT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_code,
  input  logic [31:0] req_arg,
  output logic        resp_done,
  output logic        resp_err,
  output logic        char_valid,
  output logic [7:0]  char_data,
  input  logic        char_ready,
  output logic        halted,
  output logic [31:0] stat_calls,
  output logic [31:0] stat_chars
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CONV   = 3'd1,
    ST_SIGN   = 3'd2,
    ST_DIGITS = 3'd3,
    ST_NL     = 3'd4,
    ST_CHAR   = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] bin_r, bin_s;
  logic [39:0] bcd_r, bcd_s, bcd_adj_s, bcd_shift_s, bcd_src_s;
  logic [4:0]  cnt_r, cnt_s;
  logic [3:0]  idx_r, idx_s, msd_s;
  logic        neg_r, neg_s;
  logic        halted_r, halted_s;
  logic        ready_r, ready_s;
  logic        done_r, done_s;
  logic        err_r, err_s;
  logic        cv_r, cv_s;
  logic [7:0]  cd_r, cd_s;

  // Double-dabble correction: add 3 to every BCD digit of 5 or more before shifting.
  function automatic logic [39:0] dd_adjust(input logic [39:0] v);
    logic [39:0] r;
    r = v;
    for (int i = 0; i < 10; i++) begin
      r[4*i +: 4] = (v[4*i +: 4] > 4'd4) ? (v[4*i +: 4] + 4'd3) : v[4*i +: 4];
    end
    return r;
  endfunction

  function automatic logic [3:0] msd(input logic [39:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (v[4*i +: 4] != 4'd0) begin
        r = 4'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] ascii_digit(input logic [39:0] v, input logic [3:0] i);
    logic [39:0] t;
    t = v >> {i, 2'b00};
    return 8'h30 + {4'h0, t[3:0]};
  endfunction

  assign bcd_adj_s   = dd_adjust(bcd_r);
  assign bcd_shift_s = {bcd_adj_s[38:0], bin_r[31]};
  // On the last conversion cycle the first digit comes from the value being written this cycle
  assign bcd_src_s   = (state_r == ST_CONV) ? bcd_shift_s : bcd_r;
  assign msd_s       = msd(bcd_src_s);

  // Next-state and next-output logic; every output is registered alongside the state
  always_comb begin
    state_s  = state_r;
    bin_s    = bin_r;
    bcd_s    = bcd_r;
    cnt_s    = cnt_r;
    idx_s    = idx_r;
    neg_s    = neg_r;
    halted_s = halted_r;
    done_s   = 1'b0;
    err_s    = 1'b0;
    cv_s     = 1'b0;
    cd_s     = cd_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid && ready_r) begin
          if (req_code == CODE_PRINT_INT) begin
            state_s = ST_CONV;
            bin_s   = req_arg[31] ? (32'd0 - req_arg) : req_arg;
            bcd_s   = 40'd0;
            cnt_s   = 5'd0;
            neg_s   = req_arg[31];
          end else if (req_code == CODE_PRINT_CHAR) begin
            state_s = ST_CHAR;
            cv_s    = 1'b1;
            cd_s    = req_arg[7:0];
          end else if (req_code == CODE_EXIT) begin
            state_s  = ST_DONE;
            done_s   = 1'b1;
            halted_s = 1'b1;
          end else begin
            state_s = ST_DONE;
            done_s  = 1'b1;
            err_s   = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CONV: begin
        bin_s = {bin_r[30:0], 1'b0};
        bcd_s = bcd_shift_s;
        cnt_s = cnt_r + 5'd1;
        if (cnt_r == 5'd31) begin
          if (neg_r) begin
            state_s = ST_SIGN;
            cv_s    = 1'b1;
            cd_s    = 8'h2D;
          end else begin
            state_s = ST_DIGITS;
            idx_s   = msd_s;
            cv_s    = 1'b1;
            cd_s    = ascii_digit(bcd_shift_s, msd_s);
          end
        end else begin
          state_s = ST_CONV;
        end
      end
      ST_SIGN: begin
        if (char_ready) begin
          state_s = ST_DIGITS;
          idx_s   = msd_s;
          cv_s    = 1'b1;
          cd_s    = ascii_digit(bcd_r, msd_s);
        end else begin
          cv_s = 1'b1;
        end
      end
      ST_DIGITS: begin
        if (char_ready) begin
          if (idx_r == 4'd0) begin
            if (NEWLINE_AFTER_INT) begin
              state_s = ST_NL;
              cv_s    = 1'b1;
              cd_s    = 8'h0A;
            end else begin
              state_s = ST_DONE;
              done_s  = 1'b1;
            end
          end else begin
            idx_s = idx_r - 4'd1;
            cv_s  = 1'b1;
            cd_s  = ascii_digit(bcd_r, idx_r - 4'd1);
          end
        end else begin
          cv_s = 1'b1;
        end
      end
      ST_NL, ST_CHAR: begin
        if (char_ready) begin
          state_s = ST_DONE;
          done_s  = 1'b1;
        end else begin
          cv_s = 1'b1;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    ready_s = (state_s == ST_IDLE) && !halted_s;
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      bin_r    <= 32'd0;
      bcd_r    <= 40'd0;
      cnt_r    <= 5'd0;
      idx_r    <= 4'd0;
      neg_r    <= 1'b0;
      halted_r <= 1'b0;
      ready_r  <= 1'b1;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      cv_r     <= 1'b0;
      cd_r     <= 8'h00;
    end else begin
      state_r  <= state_s;
      bin_r    <= bin_s;
      bcd_r    <= bcd_s;
      cnt_r    <= cnt_s;
      idx_r    <= idx_s;
      neg_r    <= neg_s;
      halted_r <= halted_s;
      ready_r  <= ready_s;
      done_r   <= done_s;
      err_r    <= err_s;
      cv_r     <= cv_s;
      cd_r     <= cd_s;
    end
  end

  assign req_ready  = ready_r;
  assign resp_done  = done_r;
  assign resp_err   = err_r;
  assign char_valid = cv_r;
  assign char_data  = cd_r;
  assign halted     = halted_r;

`ifdef SYSCALL_STATS_EN
  logic [31:0] calls_r, chars_r;

  // Serviced-request and transferred-byte counters, wrapping naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      calls_r <= 32'd0;
      chars_r <= 32'd0;
    end else begin
      calls_r <= done_r ? (calls_r + 32'd1) : calls_r;
      chars_r <= (cv_r && char_ready) ? (chars_r + 32'd1) : chars_r;
    end
  end

  assign stat_calls = calls_r;
  assign stat_chars = chars_r;
`else
  assign stat_calls = 32'd0;
  assign stat_chars = 32'd0;
`endif

endmodule

// File: tb/tb_syscall_console_responder.sv
// Self-checking bench: table of syscall requests, byte scoreboard, plus exit and mid-print reset sequences.
module tb_syscall_console_responder;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, resp_done, resp_err;
  logic        char_valid, char_ready, halted;
  logic [31:0] req_code, req_arg, stat_calls, stat_chars;
  logic [7:0]  char_data;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  int   cyc, done_cnt, done_cyc, nbytes, exp_calls, exp_chars;
  logic done_err, done_halt, stall_r;
  logic [7:0] stall_data;

  typedef struct {
    logic [31:0] code;
    logic [31:0] arg;
    bit          bp;
    logic        err;
  } vec_t;
  vec_t vecs[12];

  always #5 clk = ~clk;

  syscall_console_responder dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_code(req_code), .req_arg(req_arg), .resp_done(resp_done), .resp_err(resp_err),
    .char_valid(char_valid), .char_data(char_data), .char_ready(char_ready),
    .halted(halted), .stat_calls(stat_calls), .stat_chars(stat_chars)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Negedge monitor: byte scoreboard, stall stability, done pulse capture
  task automatic observe();
    cyc++;
    if (stall_r) begin
      chk("stall_valid", 32'(char_valid), 32'd1);
      chk("stall_data", 32'(char_data), 32'(stall_data));
    end
    if (char_valid && char_ready) begin
      nbytes++;
      exp_chars++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL byte: got unexpected %02h, expected no byte", char_data);
      end else begin
        chk("byte", 32'(char_data), 32'(exp_q.pop_front()));
      end
    end
    stall_r    = char_valid && !char_ready;
    stall_data = char_data;
    chk("err_only_with_done", 32'(resp_err & ~resp_done), 32'd0);
    if (resp_done) begin
      done_cnt++;
      exp_calls++;
      if (done_cnt == 1) begin
        done_cyc  = cyc;
        done_err  = resp_err;
        done_halt = halted;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    stall_r   = 1'b0;
    exp_calls = 0;
    exp_chars = 0;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_done", 32'(resp_done), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_char_valid", 32'(char_valid), 32'd0);
    chk("rst_char_data", 32'(char_data), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_stat_calls", stat_calls, 32'd0);
    chk("rst_stat_chars", stat_chars, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_req(input logic [31:0] code, input logic [31:0] arg, input bit bp,
                         input logic exp_err, input int exp_lat);
    done_cnt = 0;
    done_cyc = -1;
    nbytes   = 0;
    cyc      = 0;
    req_valid  = 1'b1;
    req_code   = code;
    req_arg    = arg;
    char_ready = 1'b1;
    @(negedge clk);
    chk("accept_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_code  = 32'hDEAD_BEEF;
    req_arg   = ~arg;
    while (done_cnt == 0 && cyc < 1000) begin
      if (bp) char_ready = ~char_ready;
      cycle();
    end
    char_ready = 1'b1;
    cycle();
    cycle();
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("resp_err", 32'(done_err), 32'(exp_err));
    chk("bytes_left", 32'(exp_q.size()), 32'd0);
    if (!bp) chk("latency", 32'(done_cyc), 32'(exp_lat));
  endtask

  initial begin
    string s;
    int lat;
    rst = 1'b1;
    req_valid = 1'b0;
    req_code = 32'd0;
    req_arg = 32'd0;
    char_ready = 1'b1;
    stall_r = 1'b0;
    stall_data = 8'h00;
    done_err = 1'b0;
    done_halt = 1'b0;
    exp_calls = 0;
    exp_chars = 0;

    vecs[0]  = '{32'd1,  32'd305,        1'b0, 1'b0};
    vecs[1]  = '{32'd1,  32'h8000_0000,  1'b0, 1'b0};
    vecs[2]  = '{32'd1,  32'd0,          1'b0, 1'b0};
    vecs[3]  = '{32'd1,  32'd0,          1'b1, 1'b0};
    vecs[4]  = '{32'd1,  32'd123456789,  1'b1, 1'b0};
    vecs[5]  = '{32'd1,  32'h7FFF_FFFF,  1'b0, 1'b0};
    vecs[6]  = '{32'd1,  32'hFFFF_FFFF,  1'b1, 1'b0};
    vecs[7]  = '{32'd1,  32'd1000000000, 1'b0, 1'b0};
    vecs[8]  = '{32'd11, 32'h0000_0141,  1'b0, 1'b0};
    vecs[9]  = '{32'd11, 32'hFFFF_FF00,  1'b1, 1'b0};
    vecs[10] = '{32'd5,  32'd42,         1'b0, 1'b1};
    vecs[11] = '{32'd1,  32'hFFFF_FF9C,  1'b0, 1'b0};

    do_reset();

    foreach (vecs[k]) begin
      if (vecs[k].code == 32'd1) begin
        s = $sformatf("%0d", $signed(vecs[k].arg));
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        exp_q.push_back(8'h0A);
        lat = 32 + s.len() + 1 + 1;
      end else if (vecs[k].code == 32'd11) begin
        exp_q.push_back(vecs[k].arg[7:0]);
        lat = 2;
      end else begin
        lat = 1;
      end
      run_req(vecs[k].code, vecs[k].arg, vecs[k].bp, vecs[k].err, lat);
    end

`ifdef SYSCALL_STATS_EN
    chk("stat_calls", stat_calls, 32'(exp_calls));
    chk("stat_chars", stat_chars, 32'(exp_chars));
`else
    chk("stat_calls_tied", stat_calls, 32'd0);
    chk("stat_chars_tied", stat_chars, 32'd0);
`endif

    // Exit: no bytes, halted with done, requests refused afterwards
    run_req(32'd10, 32'd0, 1'b0, 1'b0, 1);
    chk("halted_with_done", 32'(done_halt), 32'd1);
    chk("halted_sticky", 32'(halted), 32'd1);
    done_cnt  = 0;
    req_valid = 1'b1;
    req_code  = 32'd11;
    req_arg   = 32'h41;
    repeat (5) begin
      cycle();
      chk("ready_while_halted", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    chk("no_done_while_halted", 32'(done_cnt), 32'd0);
    do_reset();

    // Reset in the middle of the digit stream abandons the service
    s = $sformatf("%0d", 123456789);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h0A);
    cyc = 0;
    done_cnt = 0;
    nbytes = 0;
    req_valid = 1'b1;
    req_code = 32'd1;
    req_arg = 32'd123456789;
    char_ready = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    while (cyc < 35) cycle();
    chk("bytes_before_reset", 32'(nbytes), 32'd3);
    do_reset();
    done_cnt = 0;
    repeat (50) cycle();
    chk("no_done_after_reset", 32'(done_cnt), 32'd0);
    chk("idle_after_reset", 32'(char_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
